// File: rtl/decode_uop_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_uop_seq_if
// Brief    : Fetch-to-decode handshake plus decode-to-RR micro-op bundle.
//            The master side is the fetch / hazard-unit environment; the
//            slave side is the decode stage itself.
// Revision : 1.0 - initial release
// ============================================================================
interface decode_uop_seq_if #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 16,
    parameter int DATA_W  = 16,
    parameter int RIDX_W  = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               should_stall;
    logic               flush;
    logic               out_valid;
    logic [3:0]         out_opcode;
    logic [RIDX_W-1:0]  out_rd;
    logic [RIDX_W-1:0]  hdu_src1;
    logic [RIDX_W-1:0]  hdu_src2;
    logic               out_use_src1;
    logic               out_use_src2;
    logic               out_wr_rd;
    logic [1:0]         out_cond;
    logic [DATA_W-1:0]  out_imm;
    logic [PC_W-1:0]    out_pc;
    logic               out_last;
    logic               out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, should_stall, flush,
        input  in_ready, out_valid, out_opcode, out_rd, hdu_src1, hdu_src2,
               out_use_src1, out_use_src2, out_wr_rd, out_cond, out_imm,
               out_pc, out_last, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, should_stall, flush,
        output in_ready, out_valid, out_opcode, out_rd, hdu_src1, hdu_src2,
               out_use_src1, out_use_src2, out_wr_rd, out_cond, out_imm,
               out_pc, out_last, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_uop_seq.sv
`default_nettype none
// ============================================================================
// Module   : decode_uop_seq
// Brief    : Registered IITB-RISC decode stage. Extracts operand fields,
//            extends immediates, drives hazard-unit sources and expands
//            LM/SM into one LW/SW micro-op per set register-list bit.
//            Optional macro DECODE_PERF_CNT_EN adds perf_uops / perf_stall
//            free-running counters.
// Revision : 1.0 - initial release
// ============================================================================
module decode_uop_seq #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 16,
    parameter int DATA_W  = 16,
    parameter int NREG    = 8,
    parameter int RIDX_W  = 3     // must equal clog2(NREG)
) (
    input  wire              clk,
    input  wire              rst,
    decode_uop_seq_if.slave  dec_if
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]      perf_uops,
    output logic [31:0]      perf_stall
`endif
);
    localparam logic [3:0] c_OP_ADI = 4'b0000;
    localparam logic [3:0] c_OP_ADD = 4'b0001;
    localparam logic [3:0] c_OP_NDU = 4'b0010;
    localparam logic [3:0] c_OP_LHI = 4'b0011;
    localparam logic [3:0] c_OP_LW  = 4'b0100;
    localparam logic [3:0] c_OP_SW  = 4'b0101;
    localparam logic [3:0] c_OP_BEQ = 4'b1000;
    localparam logic [3:0] c_OP_JAL = 4'b1001;
    localparam logic [3:0] c_OP_JLR = 4'b1010;
    localparam logic [3:0] c_OP_JRI = 4'b1011;
    localparam logic [3:0] c_OP_LM  = 4'b1100;
    localparam logic [3:0] c_OP_SM  = 4'b1101;
    localparam logic [3:0] c_OP_IL0 = 4'b1110;
    localparam logic [3:0] c_OP_IL1 = 4'b1111;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_MULTI = 1'b1;

    typedef struct packed {
        logic              valid;
        logic [3:0]        opcode;
        logic [RIDX_W-1:0] rd;
        logic [RIDX_W-1:0] src1;
        logic [RIDX_W-1:0] src2;
        logic              use1;
        logic              use2;
        logic              wr;
        logic [1:0]        cond;
        logic [DATA_W-1:0] imm;
        logic [PC_W-1:0]   pc;
        logic              last;
        logic              illegal;
    } uop_t;

    // Index of the lowest set bit in a register list.
    function automatic logic [RIDX_W-1:0] f_lowest(input logic [NREG-1:0] l);
        logic [RIDX_W-1:0] idx;
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (l[i]) idx = RIDX_W'(i);
        end
        return idx;
    endfunction

    // One LW (from LM) or SW (from SM) micro-op; imm carries the word offset k.
    function automatic uop_t f_mem_uop(input logic is_sm, input logic [RIDX_W-1:0] base,
                                       input logic [RIDX_W-1:0] idx, input logic [RIDX_W-1:0] k,
                                       input logic [PC_W-1:0] pc, input logic last);
        uop_t u;
        u       = '0;
        u.valid = 1'b1;
        u.pc    = pc;
        u.last  = last;
        u.imm   = DATA_W'(k);
        u.src1  = base;
        u.use1  = 1'b1;
        if (is_sm) begin
            u.opcode = c_OP_SW;
            u.src2   = idx;
            u.use2   = 1'b1;
        end else begin
            u.opcode = c_OP_LW;
            u.rd     = idx;
            u.wr     = 1'b1;
        end
        return u;
    endfunction

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    uop_t              r_uop;
    uop_t              w_uop_nxt;
    logic [RIDX_W-1:0] r_ra, w_ra_nxt;
    logic [NREG-1:0]   r_list, w_list_nxt;
    logic [RIDX_W-1:0] r_k, w_k_nxt;
    logic [PC_W-1:0]   r_pc, w_pc_nxt;
    logic              r_is_sm, w_is_sm_nxt;

    logic [3:0]        w_op;
    logic [RIDX_W-1:0] w_ra, w_rb, w_rc;
    logic [DATA_W-1:0] w_sext6, w_sext9, w_lhi;
    logic [NREG-1:0]   w_in_list, w_in_rem, w_cur_rem;

    assign w_op      = dec_if.in_instr[INSTR_W-1 -: 4];
    assign w_ra      = dec_if.in_instr[11:9];
    assign w_rb      = dec_if.in_instr[8:6];
    assign w_rc      = dec_if.in_instr[5:3];
    assign w_sext6   = {{(DATA_W-6){dec_if.in_instr[5]}}, dec_if.in_instr[5:0]};
    assign w_sext9   = {{(DATA_W-9){dec_if.in_instr[8]}}, dec_if.in_instr[8:0]};
    assign w_lhi     = DATA_W'(dec_if.in_instr[8:0]) << 7;
    assign w_in_list = dec_if.in_instr[NREG-1:0];
    assign w_in_rem  = w_in_list & (w_in_list - NREG'(1));
    assign w_cur_rem = r_list & (r_list - NREG'(1));

    assign dec_if.in_ready = !rst && (r_state == c_ST_IDLE) && !dec_if.should_stall && !dec_if.flush;

    // Next-state and next micro-op: flush beats stall, stall beats progress.
    always_comb begin
        w_state_nxt = r_state;
        w_uop_nxt   = r_uop;
        w_ra_nxt    = r_ra;
        w_list_nxt  = r_list;
        w_k_nxt     = r_k;
        w_pc_nxt    = r_pc;
        w_is_sm_nxt = r_is_sm;
        if (dec_if.flush) begin
            w_uop_nxt.valid = 1'b0;
            w_state_nxt     = c_ST_IDLE;
            w_list_nxt      = '0;
        end else if (dec_if.should_stall) begin
            w_uop_nxt = r_uop;
        end else if (r_state == c_ST_MULTI) begin
            w_uop_nxt  = f_mem_uop(r_is_sm, r_ra, f_lowest(r_list), r_k, r_pc, w_cur_rem == '0);
            w_list_nxt = w_cur_rem;
            w_k_nxt    = r_k + RIDX_W'(1);
            if (w_cur_rem == '0) w_state_nxt = c_ST_IDLE;
        end else if (dec_if.in_valid) begin
            w_uop_nxt        = '0;
            w_uop_nxt.valid  = 1'b1;
            w_uop_nxt.opcode = w_op;
            w_uop_nxt.pc     = dec_if.in_pc;
            w_uop_nxt.last   = 1'b1;
            case (w_op)
                c_OP_ADD, c_OP_NDU: begin
                    w_uop_nxt.rd   = w_rc;
                    w_uop_nxt.src1 = w_ra;
                    w_uop_nxt.src2 = w_rb;
                    w_uop_nxt.use1 = 1'b1;
                    w_uop_nxt.use2 = 1'b1;
                    w_uop_nxt.wr   = 1'b1;
                    w_uop_nxt.cond = dec_if.in_instr[1:0];
                end
                c_OP_ADI: begin
                    w_uop_nxt.rd   = w_rb;
                    w_uop_nxt.src1 = w_ra;
                    w_uop_nxt.use1 = 1'b1;
                    w_uop_nxt.wr   = 1'b1;
                    w_uop_nxt.imm  = w_sext6;
                end
                c_OP_LW: begin
                    w_uop_nxt.rd   = w_ra;
                    w_uop_nxt.src1 = w_rb;
                    w_uop_nxt.use1 = 1'b1;
                    w_uop_nxt.wr   = 1'b1;
                    w_uop_nxt.imm  = w_sext6;
                end
                c_OP_SW, c_OP_BEQ: begin
                    w_uop_nxt.src1 = (w_op == c_OP_SW) ? w_rb : w_ra;
                    w_uop_nxt.src2 = (w_op == c_OP_SW) ? w_ra : w_rb;
                    w_uop_nxt.use1 = 1'b1;
                    w_uop_nxt.use2 = 1'b1;
                    w_uop_nxt.imm  = w_sext6;
                end
                c_OP_LHI: begin
                    w_uop_nxt.rd  = w_ra;
                    w_uop_nxt.wr  = 1'b1;
                    w_uop_nxt.imm = w_lhi;
                end
                c_OP_JAL: begin
                    w_uop_nxt.rd  = w_ra;
                    w_uop_nxt.wr  = 1'b1;
                    w_uop_nxt.imm = w_sext9;
                end
                c_OP_JLR: begin
                    w_uop_nxt.rd   = w_ra;
                    w_uop_nxt.wr   = 1'b1;
                    w_uop_nxt.src1 = w_rb;
                    w_uop_nxt.use1 = 1'b1;
                end
                c_OP_JRI: begin
                    w_uop_nxt.src1 = w_ra;
                    w_uop_nxt.use1 = 1'b1;
                    w_uop_nxt.imm  = w_sext9;
                end
                c_OP_LM, c_OP_SM: begin
                    // An empty list keeps the LM/SM opcode as a PC-carrying NOP.
                    if (w_in_list != '0) begin
                        w_uop_nxt   = f_mem_uop(w_op == c_OP_SM, w_ra, f_lowest(w_in_list),
                                                '0, dec_if.in_pc, w_in_rem == '0);
                        w_ra_nxt    = w_ra;
                        w_list_nxt  = w_in_rem;
                        w_pc_nxt    = dec_if.in_pc;
                        w_k_nxt     = RIDX_W'(1);
                        w_is_sm_nxt = (w_op == c_OP_SM);
                        if (w_in_rem != '0) w_state_nxt = c_ST_MULTI;
                    end
                end
                c_OP_IL0, c_OP_IL1: begin
                    w_uop_nxt.illegal = 1'b1;
                end
                default: ;
            endcase
        end else begin
            w_uop_nxt.valid = 1'b0;
        end
    end

    // State, latched LM/SM context and registered micro-op outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_uop   <= '0;
            r_ra    <= '0;
            r_list  <= '0;
            r_k     <= '0;
            r_pc    <= '0;
            r_is_sm <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_uop   <= w_uop_nxt;
            r_ra    <= w_ra_nxt;
            r_list  <= w_list_nxt;
            r_k     <= w_k_nxt;
            r_pc    <= w_pc_nxt;
            r_is_sm <= w_is_sm_nxt;
        end
    end

    assign dec_if.out_valid    = r_uop.valid;
    assign dec_if.out_opcode   = r_uop.opcode;
    assign dec_if.out_rd       = r_uop.rd;
    assign dec_if.hdu_src1     = r_uop.src1;
    assign dec_if.hdu_src2     = r_uop.src2;
    assign dec_if.out_use_src1 = r_uop.use1;
    assign dec_if.out_use_src2 = r_uop.use2;
    assign dec_if.out_wr_rd    = r_uop.wr;
    assign dec_if.out_cond     = r_uop.cond;
    assign dec_if.out_imm      = r_uop.imm;
    assign dec_if.out_pc       = r_uop.pc;
    assign dec_if.out_last     = r_uop.last;
    assign dec_if.out_illegal  = r_uop.illegal;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] r_perf_uops;
    logic [31:0] r_perf_stall;

    // Transferred micro-ops and stalled-valid cycles; flush does not clear them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_uops  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_uop.valid && !dec_if.should_stall) r_perf_uops <= r_perf_uops + 32'd1;
            if (r_uop.valid && dec_if.should_stall)  r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_uops  = r_perf_uops;
    assign perf_stall = r_perf_stall;
`endif
endmodule
`default_nettype wire
